// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: major opcodes and the destination-write predicate.
package rv32i_pkg;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;

  function automatic logic writes_rd(input logic [6:0] opcode);
    logic w;
    case (opcode)
      OPC_LOAD, OPC_JAL, OPC_JALR, OPC_LUI,
      OPC_AUIPC, OPC_OP, OPC_OPIMM:                      w = 1'b1;
      OPC_STORE, OPC_BRANCH, OPC_SYSTEM, OPC_MISCMEM:    w = 1'b0;
      default:                                           w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/regfile.sv
// 31x32 integer register file (x0 hardwired to zero) with one write port and
// two read ports that bypass the in-flight write.
module regfile #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [4:0]       waddr,
  input  logic [Width-1:0] wdata,
  input  logic [4:0]       raddr1,
  input  logic [4:0]       raddr2,
  output logic [Width-1:0] rdata1,
  output logic [Width-1:0] rdata2
);

  logic [Width-1:0] regs [31:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (raddr1 != 5'd0) begin
      rdata1 = (we && raddr1 == waddr) ? wdata : regs[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (raddr2 != 5'd0) begin
      rdata2 = (we && raddr2 == waddr) ? wdata : regs[raddr2];
    end
  end

endmodule

// File: rtl/wb_stage.sv
// RV32I write-back stage: selects the result by opcode, commits it to the
// register file, publishes a one-cycle forwarding record and counts retirements.
module wb_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_from_mem,
  input  logic                 stall,
  input  logic [XLEN-1:0]      pc_from_mem,
  input  logic [4:0]           rd_from_mem,
  input  logic [6:0]           opcode_from_mem,
  input  logic [XLEN-1:0]      c_from_mem,
  input  logic [XLEN-1:0]      d_from_mem,
  input  logic [4:0]           rs1_addr,
  input  logic [4:0]           rs2_addr,
  output logic [XLEN-1:0]      rs1_data,
  output logic [XLEN-1:0]      rs2_data,
  output logic                 fwd_valid,
  output logic [4:0]           fwd_rd,
  output logic [XLEN-1:0]      fwd_data,
  output logic [INSTRET_W-1:0] instret
);

  logic            commit;
  logic            we;
  logic [XLEN-1:0] wb_value;

  assign commit = valid_from_mem & ~stall;
  assign we     = commit & writes_rd(opcode_from_mem) & (rd_from_mem != 5'd0);

  // Link address wraps naturally at 2^32.
  always_comb begin
    wb_value = c_from_mem;
    case (opcode_from_mem)
      OPC_LOAD:          wb_value = d_from_mem;
      OPC_JAL, OPC_JALR: wb_value = pc_from_mem + XLEN'(4);
      default:           wb_value = c_from_mem;
    endcase
  end

  regfile #(
    .Width (XLEN)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .waddr  (rd_from_mem),
    .wdata  (wb_value),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid <= 1'b0;
      fwd_rd    <= 5'd0;
      fwd_data  <= '0;
      instret   <= '0;
    end else begin
      fwd_valid <= we;
      fwd_rd    <= we ? rd_from_mem : 5'd0;
      fwd_data  <= we ? wb_value : '0;
      if (commit) instret <= instret + INSTRET_W'(1);
    end
  end

endmodule
